// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: one-hot instruction bit positions, IDCODE width and DR select encoding.
package jtag_pkg;

   localparam int I_BYPASS         = 0;
   localparam int I_SAMPLE_PRELOAD = 1;
   localparam int I_EXTEST         = 2;
   localparam int I_INTEST         = 3;
   localparam int I_IDCODE         = 4;
   localparam int I_CLAMP          = 5;

   localparam int IDCODE_W = 32;

   typedef enum logic [1:0] {
      DR_BYPASS,
      DR_IDCODE,
      DR_BSR
   } dr_sel_t;

endpackage

// File: rtl/jtag_shift_dr.sv
// Generic capture/shift data register, shifted LSB-out toward TDO; reset value equals capture value.
module jtag_shift_dr #(
   parameter int           W             = 1,
   parameter logic [W-1:0] CAPTURE_VALUE = '0
) (
   input  logic tck,
   input  logic tl_reset,
   input  logic tdi,
   input  logic capture,
   input  logic shift,
   output logic sout
);

   logic [W-1:0] data;
   logic [W:0]   shifted_ext;

   // tdi enters at the MSB; the W=1 case degenerates to a plain flop
   assign shifted_ext = {tdi, data};
   assign sout        = data[0];

   always_ff @(posedge tck or negedge tl_reset) begin
      if (!tl_reset) begin
         data <= CAPTURE_VALUE;
      end else if (capture) begin
         data <= CAPTURE_VALUE;
      end else if (shift) begin
         data <= shifted_ext[W:1];
      end
   end

endmodule

// File: rtl/data_register_path.sv
// JTAG DR path: BYPASS/IDCODE registers, BSR strobe gating and falling-edge TDO retime.
// Optional DR_SHIFT_COUNT_EN adds a saturating dr_shift_count output.
module data_register_path
   import jtag_pkg::*;
#(
   parameter int          INST_COUNT   = 6,
   parameter logic [31:0] IDCODE_VALUE = 32'h1234_5677
) (
   input  logic                  tck,
   input  logic                  tl_reset,
   input  logic                  tdi,
   input  logic                  captureDR,
   input  logic                  shiftDR,
   input  logic                  updateDR,
   input  logic                  shiftIR,
   input  logic                  ir_tdo,
   input  logic [INST_COUNT-1:0] instructions,
   input  logic                  bsr_tdo,
   output logic                  bsr_capture,
   output logic                  bsr_shift,
   output logic                  bsr_update,
   output logic                  bsr_mode_out,
   output logic                  bsr_mode_in,
   output logic                  tdo,
   output logic                  tdo_en
`ifdef DR_SHIFT_COUNT_EN
   ,
   output logic [15:0]           dr_shift_count
`endif
);

   localparam logic [INST_COUNT-1:0] ONE = {{(INST_COUNT-1){1'b0}}, 1'b1};

   dr_sel_t dr_sel;
   logic    inst_onehot;
   logic    bsr_sel;
   logic    idcode_lsb;
   logic    bypass_lsb;
   logic    serial;

   assign inst_onehot = (instructions != '0) && ((instructions & (instructions - ONE)) == '0);

   // Anything not cleanly one-hot falls back to BYPASS so BSR is never touched by accident
   always_comb begin
      dr_sel = DR_BYPASS;
      if (inst_onehot) begin
         if (instructions[I_IDCODE]) begin
            dr_sel = DR_IDCODE;
         end else if (instructions[I_SAMPLE_PRELOAD] | instructions[I_EXTEST] | instructions[I_INTEST]) begin
            dr_sel = DR_BSR;
         end
      end
   end

   assign bsr_sel      = (dr_sel == DR_BSR);
   assign bsr_capture  = captureDR & bsr_sel;
   assign bsr_shift    = shiftDR & bsr_sel;
   assign bsr_update   = updateDR & bsr_sel;
   assign bsr_mode_out = inst_onehot & (instructions[I_EXTEST] | instructions[I_CLAMP]);
   assign bsr_mode_in  = inst_onehot & instructions[I_INTEST];

   jtag_shift_dr #(.W(IDCODE_W), .CAPTURE_VALUE(IDCODE_VALUE)) u_idcode (
      .tck      (tck),
      .tl_reset (tl_reset),
      .tdi      (tdi),
      .capture  (captureDR & (dr_sel == DR_IDCODE)),
      .shift    (shiftDR & (dr_sel == DR_IDCODE)),
      .sout     (idcode_lsb)
   );

   jtag_shift_dr #(.W(1), .CAPTURE_VALUE(1'b0)) u_bypass (
      .tck      (tck),
      .tl_reset (tl_reset),
      .tdi      (tdi),
      .capture  (captureDR & (dr_sel == DR_BYPASS)),
      .shift    (shiftDR & (dr_sel == DR_BYPASS)),
      .sout     (bypass_lsb)
   );

   always_comb begin
      serial = 1'b0;
      if (shiftIR) begin
         serial = ir_tdo;
      end else if (shiftDR) begin
         case (dr_sel)
            DR_IDCODE: serial = idcode_lsb;
            DR_BSR:    serial = bsr_tdo;
            default:   serial = bypass_lsb;
         endcase
      end
   end

   // Falling-edge retime gives the receiver half a TCK of setup
   always_ff @(negedge tck or negedge tl_reset) begin
      if (!tl_reset) begin
         tdo    <= 1'b0;
         tdo_en <= 1'b0;
      end else begin
         tdo    <= serial;
         tdo_en <= shiftIR | shiftDR;
      end
   end

`ifdef DR_SHIFT_COUNT_EN
   logic [15:0] dr_shift_count_q;

   always_ff @(posedge tck or negedge tl_reset) begin
      if (!tl_reset) begin
         dr_shift_count_q <= '0;
      end else if (captureDR) begin
         dr_shift_count_q <= '0;
      end else if (shiftDR && (dr_shift_count_q != 16'hFFFF)) begin
         dr_shift_count_q <= dr_shift_count_q + 16'd1;
      end
   end

   assign dr_shift_count = dr_shift_count_q;
`endif

endmodule

// File: tb/tb_data_register_path.sv
// Bench for data_register_path: queue-based DR model, per-cycle compare, directed literal checks.
module tb_data_register_path;

   localparam logic [31:0] IDV = 32'h1234_5677;
   localparam logic [5:0]  BYP = 6'b000001;
   localparam logic [5:0]  EXT = 6'b000100;
   localparam logic [5:0]  IDC = 6'b010000;
   localparam logic [5:0]  INV = 6'b000011;

   logic       tck = 1'b0;
   logic       tl_reset = 1'b0;
   logic       tdi = 1'b0, captureDR = 1'b0, shiftDR = 1'b0, updateDR = 1'b0, shiftIR = 1'b0;
   logic       ir_tdo = 1'b0, bsr_tdo = 1'b0;
   logic [5:0] instructions = BYP;
   logic       bsr_capture, bsr_shift, bsr_update, bsr_mode_out, bsr_mode_in, tdo, tdo_en;
`ifdef DR_SHIFT_COUNT_EN
   logic [15:0] dr_shift_count;
`endif

   int checks = 0;
   int failures = 0;

   data_register_path dut (
      .tck          (tck),
      .tl_reset     (tl_reset),
      .tdi          (tdi),
      .captureDR    (captureDR),
      .shiftDR      (shiftDR),
      .updateDR     (updateDR),
      .shiftIR      (shiftIR),
      .ir_tdo       (ir_tdo),
      .instructions (instructions),
      .bsr_tdo      (bsr_tdo),
      .bsr_capture  (bsr_capture),
      .bsr_shift    (bsr_shift),
      .bsr_update   (bsr_update),
      .bsr_mode_out (bsr_mode_out),
      .bsr_mode_in  (bsr_mode_in),
      .tdo          (tdo),
      .tdo_en       (tdo_en)
`ifdef DR_SHIFT_COUNT_EN
      ,
      .dr_shift_count (dr_shift_count)
`endif
   );

   always #5 tck = ~tck;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: 0=bypass, 1=idcode, 2=bsr ----------------
   bit m_id_q[$];
   bit m_byp;
   int m_cnt;
   int m_sel;
   logic exp_tdo, exp_en;

   function automatic int sel_of(input logic [5:0] ins);
      if ($countones(ins) != 1) return 0;
      case (ins)
         6'b010000:                       return 1;
         6'b000010, 6'b000100, 6'b001000: return 2;
         default:                         return 0;
      endcase
   endfunction

   function automatic void load_id();
      logic [31:0] v;
      v = IDV;
      m_id_q.delete();
      for (int i = 0; i < 32; i++) m_id_q.push_back(v[i]);
   endfunction

   always @(posedge tck or negedge tl_reset) begin
      if (!tl_reset) begin
         load_id();
         m_byp = 1'b0;
         m_cnt = 0;
      end else begin
         m_sel = sel_of(instructions);
         if (captureDR) begin
            if (m_sel == 1) load_id();
            if (m_sel == 0) m_byp = 1'b0;
            m_cnt = 0;
         end else if (shiftDR) begin
            if (m_sel == 1) begin
               void'(m_id_q.pop_front());
               m_id_q.push_back(tdi);
            end
            if (m_sel == 0) m_byp = tdi;
            if (m_cnt < 65535) m_cnt++;
         end
      end
   end

   always @(negedge tck or negedge tl_reset) begin
      if (!tl_reset) begin
         exp_tdo = 1'b0;
         exp_en  = 1'b0;
      end else begin
         exp_en = shiftIR | shiftDR;
         if (shiftIR) exp_tdo = ir_tdo;
         else if (shiftDR) begin
            case (sel_of(instructions))
               1:       exp_tdo = m_id_q[0];
               2:       exp_tdo = bsr_tdo;
               default: exp_tdo = m_byp;
            endcase
         end else exp_tdo = 1'b0;
      end
   end

   // per-cycle compare against the model
   always @(negedge tck) begin
      #2;
      chk("tdo", tdo, exp_tdo);
      chk("tdo_en", tdo_en, exp_en);
      chk("bsr_capture", bsr_capture, (sel_of(instructions) == 2) && captureDR);
      chk("bsr_shift", bsr_shift, (sel_of(instructions) == 2) && shiftDR);
      chk("bsr_update", bsr_update, (sel_of(instructions) == 2) && updateDR);
      chk("bsr_mode_out", bsr_mode_out, (instructions == 6'b000100) || (instructions == 6'b100000));
      chk("bsr_mode_in", bsr_mode_in, instructions == 6'b001000);
`ifdef DR_SHIFT_COUNT_EN
      chk("dr_shift_count", dr_shift_count, m_cnt);
`endif
   end

   // one TCK cycle: drive just after posedge, return at negedge+2 for sampling
   task automatic cyc(input logic [5:0] ins, input logic cap, input logic sh, input logic up,
                      input logic sir, input logic d);
      @(posedge tck);
      #1;
      instructions = ins;
      captureDR = cap;
      shiftDR = sh;
      updateDR = up;
      shiftIR = sir;
      tdi = d;
      @(negedge tck);
      #2;
   endtask

   logic [31:0] word;
   logic [7:0]  byte_v;
   logic [3:0]  nib;

   initial begin
      #12;
      chk("reset_tdo", tdo, 1'b0);
      chk("reset_tdo_en", tdo_en, 1'b0);
      tl_reset = 1'b1;

      // IDCODE full readout
      cyc(IDC, 1, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) begin
         cyc(IDC, 0, 1, 0, 0, 0);
         word[i] = tdo;
         if (i == 0) chk("idcode_tdo_en_shift", tdo_en, 1'b1);
      end
      cyc(IDC, 0, 0, 0, 0, 0);
      chk("idcode_tdo_en_after", tdo_en, 1'b0);
      chk("idcode_word", word, 32'h1234_5677);

      // BYPASS one-bit delay
      cyc(BYP, 1, 0, 0, 0, 0);
      cyc(BYP, 0, 1, 0, 0, 1); nib[0] = tdo;
      cyc(BYP, 0, 1, 0, 0, 0); nib[1] = tdo;
      cyc(BYP, 0, 1, 0, 0, 1); nib[2] = tdo;
      cyc(BYP, 0, 1, 0, 0, 1); nib[3] = tdo;
      chk("bypass_seq", nib, 4'b1010);
      cyc(BYP, 0, 0, 0, 0, 0);

      // EXTEST, then resume IDCODE without capture: its contents must survive
      cyc(IDC, 1, 0, 0, 0, 0);
      cyc(EXT, 1, 0, 0, 0, 0);
      chk("extest_capture", bsr_capture, 1'b1);
      chk("extest_mode_out", bsr_mode_out, 1'b1);
      for (int i = 0; i < 8; i++) begin
         bsr_tdo = (i % 3 == 0);
         cyc(EXT, 0, 1, 0, 0, 1);
         chk("extest_tdo_bsr", tdo, (i % 3 == 0));
         if (i == 0) chk("extest_shift", bsr_shift, 1'b1);
      end
      cyc(EXT, 0, 0, 1, 0, 0);
      chk("extest_update", bsr_update, 1'b1);
      for (int i = 0; i < 8; i++) begin
         cyc(IDC, 0, 1, 0, 0, 0);
         byte_v[i] = tdo;
      end
      chk("idcode_kept", byte_v, 8'h77);

      // invalid multi-hot instruction
      cyc(INV, 1, 0, 0, 0, 0);
      chk("inv_capture", bsr_capture, 1'b0);
      chk("inv_mode_out", bsr_mode_out, 1'b0);
      chk("inv_mode_in", bsr_mode_in, 1'b0);
      cyc(INV, 0, 1, 1, 0, 1);
      chk("inv_shift", bsr_shift, 1'b0);
      chk("inv_update", bsr_update, 1'b0);
      chk("inv_tdo0", tdo, 1'b0);
      cyc(INV, 0, 1, 0, 0, 0);
      chk("inv_tdo1", tdo, 1'b1);

      // shiftIR path and priority
      ir_tdo = 1'b1;
      cyc(BYP, 0, 0, 0, 1, 0);
      chk("ir_tdo1", tdo, 1'b1);
      ir_tdo = 1'b0;
      cyc(BYP, 0, 0, 0, 1, 0);
      chk("ir_tdo0", tdo, 1'b0);
      cyc(BYP, 1, 0, 0, 0, 0);
      ir_tdo = 1'b1;
      cyc(BYP, 0, 1, 0, 1, 0);
      chk("ir_priority", tdo, 1'b1);
      ir_tdo = 1'b0;

      // reset mid IDCODE shift
      cyc(IDC, 1, 0, 0, 0, 0);
      cyc(IDC, 0, 1, 0, 0, 0);
      cyc(IDC, 0, 1, 0, 0, 0);
      cyc(IDC, 0, 1, 0, 0, 0);
      chk("pre_reset_tdo", tdo, 1'b1);
      #1 tl_reset = 1'b0;
      #1;
      chk("midreset_tdo", tdo, 1'b0);
      chk("midreset_tdo_en", tdo_en, 1'b0);
      @(posedge tck);
      #1;
      captureDR = 1'b0;
      shiftDR = 1'b0;
      tl_reset = 1'b1;
      cyc(IDC, 1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         cyc(IDC, 0, 1, 0, 0, 0);
         byte_v[i] = tdo;
      end
      chk("post_reset_idcode", byte_v, 8'h77);
      cyc(IDC, 0, 0, 0, 0, 0);

`ifdef DR_SHIFT_COUNT_EN
      cyc(BYP, 1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(BYP, 0, 1, 0, 0, 0);
      cyc(BYP, 0, 0, 0, 0, 0);
      chk("count_five", dr_shift_count, 16'd5);
      cyc(BYP, 1, 0, 0, 0, 0);
      cyc(BYP, 0, 0, 0, 0, 0);
      chk("count_clear", dr_shift_count, 16'd0);
      @(posedge tck);
      #1;
      force dut.dr_shift_count_q = 16'hFFFF;
      m_cnt = 65535;
      #1 release dut.dr_shift_count_q;
      @(negedge tck);
      #2;
      cyc(BYP, 0, 1, 0, 0, 0);
      cyc(BYP, 0, 0, 0, 0, 0);
      chk("count_saturate", dr_shift_count, 16'hFFFF);
`endif

      cyc(BYP, 0, 0, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
